// File: rtl/viterbi_pkg.sv
// Viterbi decoder control: shared types and constants.
// Frame-state enum, default frame length, metric-clear level.
package viterbi_pkg;

  localparam int FRAME_LEN_DEF = 16;

  // pm_clr level that zeroes state 0 and saturates the rest
  localparam logic PM_CLR_ON = 1'b1;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    TRACE  = 2'd1,
    DRAIN  = 2'd2
  } vit_state_t;

endpackage

// File: rtl/viterbi_ctrl_if.sv
// Received-symbol valid/ready handshake.
// master drives pairs, slave is the controller.
interface viterbi_ctrl_if;

  logic       in_valid;
  logic [1:0] rx_pair;
  logic       in_ready;

  modport master (
    output in_valid,
    output rx_pair,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  rx_pair,
    output in_ready
  );

endinterface

// File: rtl/vit_addr_cnt.sv
// Survivor address counter: load, up/down step.
// term flags all-ones counting up, zero counting down.
module vit_addr_cnt #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [AW-1:0] ld_val,
  input  logic          en,
  input  logic          dn,
  output logic [AW-1:0] cnt,
  output logic          term
);

  // load wins over step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= dn ? cnt - 1'b1 : cnt + 1'b1;
    end
  end

  // terminal value depends on direction
  always_comb begin
    term = dn ? (cnt == '0) : (cnt == '1);
  end

endmodule

// File: rtl/viterbi_ctrl.sv
// Viterbi frame controller: accept, traceback, drain.
// Sequences ACS strobes, survivor writes and reads.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int AW = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  viterbi_ctrl_if.slave sym,
  input  logic          pm_msb_all,
  output logic [1:0]    bmc_rx_pair,
  output logic          acs_en,
  output logic          pm_clr,
  output logic          pm_norm,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          dec_valid,
  output logic          frame_done
);

  vit_state_t    state_q;
  vit_state_t    state_d;
  logic          hs;
  logic          rdy;
  logic [AW-1:0] sym_cnt;
  logic          sym_term;
  logic          rd_term;
  logic          last_hs;
  logic          booted;
  logic          boot_clr;
  logic          pend;

  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  assign rdy = (state_q == ACCEPT) && booted && !boot_clr;
  assign sym.in_ready = rdy;
  assign hs = sym.in_valid && rdy;
  assign last_hs = hs && sym_term;

  vit_addr_cnt #(.AW(AW)) u_sym_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (last_hs),
    .ld_val ('0),
    .en     (hs),
    .dn     (1'b0),
    .cnt    (sym_cnt),
    .term   (sym_term)
  );

  vit_addr_cnt #(.AW(AW)) u_rd_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (last_hs),
    .ld_val (LAST),
    .en     (rd_en && !rd_term),
    .dn     (1'b1),
    .cnt    (rd_addr),
    .term   (rd_term)
  );

  // frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCEPT;
    else        state_q <= state_d;
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        if (last_hs) state_d = TRACE;
      end
      TRACE: begin
        rd_en = 1'b1;
        if (rd_term) state_d = DRAIN;
      end
      DRAIN: begin
        frame_done = 1'b1;
        state_d    = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // metric clear at boot and after each frame
  always_comb begin
    pm_clr = (frame_done || boot_clr)
           ? PM_CLR_ON : ~PM_CLR_ON;
    pm_norm = acs_en && pend;
  end

  // boot sequencing: one clear cycle, then ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      booted   <= 1'b0;
      boot_clr <= 1'b0;
    end else begin
      booted   <= 1'b1;
      boot_clr <= !booted;
    end
  end

  // one-cycle-late ACS/write strobes and dec_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmc_rx_pair <= '0;
      acs_en      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      dec_valid   <= 1'b0;
    end else begin
      acs_en    <= hs;
      wr_en     <= hs;
      dec_valid <= rd_en;
      if (hs) begin
        bmc_rx_pair <= sym.rx_pair;
        wr_addr     <= sym_cnt;
      end
    end
  end

  // normalisation request armed only by ACS cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (pm_clr == PM_CLR_ON) begin
      pend <= 1'b0;
    end else if (acs_en) begin
      pend <= pm_msb_all;
    end
  end

endmodule
